// File: rtl/sysid_pkg.sv
// sysid_pkg -- shared constants for the system-identification register block.
//   Word offsets of every register, STATUS field positions, the CONFIG word
//   layout and the legal parameter ranges used by sysid_ctrl.
package sysid_pkg;

    // Word offsets
    localparam int unsigned OFF_ID      = 0;
    localparam int unsigned OFF_TS      = 1;
    localparam int unsigned OFF_UPLO    = 2;
    localparam int unsigned OFF_UPHI    = 3;
    localparam int unsigned OFF_SCRATCH = 4;
    localparam int unsigned OFF_CONFIG  = 5;
    localparam int unsigned OFF_STATUS  = 6;
    localparam int unsigned OFF_USER    = 8;

    // STATUS fields: ERR sticky flag, ERRCNT saturating byte
    localparam int unsigned STATUS_ERR_BIT = 0;
    localparam int unsigned STATUS_CNT_LSB = 8;

    // Parameter legality limits
    localparam int unsigned NUM_USER_MIN = 1;
    localparam int unsigned NUM_USER_MAX = 16;
    localparam int unsigned ADDR_W_MIN   = 5;
    localparam int unsigned ADDR_W_MAX   = 8;

    // Decoded register selection
    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_ID,
        SEL_TS,
        SEL_UPLO,
        SEL_UPHI,
        SEL_SCRATCH,
        SEL_CONFIG,
        SEL_STATUS,
        SEL_USER
    } reg_sel_e;

    // CONFIG = {16'h0, ADDR_W[7:0], NUM_USER[7:0]}
    function automatic logic [31:0] config_word(input int unsigned addr_w,
                                                input int unsigned num_user);
        return {16'h0000, 8'(addr_w), 8'(num_user)};
    endfunction

    // Byte-lane merge for writable registers
    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sysid_uptime.sv
// sysid_uptime -- 64-bit free-running uptime counter with a high-word shadow.
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset (counter and shadow cleared)
//   snap     : copy counter[63:32] into the shadow at this edge
//   lo       : live counter[31:0]
//   hi       : shadow of counter[63:32] from the last snap
module sysid_uptime (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [63:0] cnt;
    logic [31:0] shadow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else begin
            cnt <= cnt + 64'd1;
            // Same pre-increment sample the caller registers as the low word
            if (snap) shadow <= cnt[63:32];
        end
    end

    assign lo = cnt[31:0];
    assign hi = shadow;

endmodule

// File: rtl/sysid_ctrl.sv
// sysid_ctrl -- Avalon-MM system-identification / control register block.
//   clk, reset_n        : rising-edge clock, synchronous active-low reset
//   address             : word address (ADDR_W bits)
//   read, write         : single-cycle strobes, no waitrequest
//   writedata/byteenable: write data and byte lanes (lanes ignored on reads)
//   readdata            : registered read data, zero when readdatavalid = 0
//   readdatavalid       : one-cycle pulse, exactly one cycle after a read
//   irq                 : registered copy of STATUS.ERR
module sysid_ctrl
    import sysid_pkg::*;
#(
    parameter logic [31:0]            ID_VALUE  = 32'h2478_C34F,
    parameter logic [31:0]            TIMESTAMP = 32'h0000_0000,
    parameter int unsigned            NUM_USER  = 4,
    parameter logic [32*NUM_USER-1:0] USER_INIT = '0,
    parameter int unsigned            ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    output logic              irq
);

    if (NUM_USER < NUM_USER_MIN || NUM_USER > NUM_USER_MAX) begin : g_bad_num_user
        $error("sysid_ctrl: NUM_USER out of range");
    end
    if (ADDR_W < ADDR_W_MIN || ADDR_W > ADDR_W_MAX) begin : g_bad_addr_w
        $error("sysid_ctrl: ADDR_W out of range");
    end
    if (OFF_USER + NUM_USER > (1 << ADDR_W)) begin : g_bad_map
        $error("sysid_ctrl: USER words do not fit in the address space");
    end

    logic [31:0] scratch;
    logic [31:0] user [NUM_USER];
    logic        err;
    logic [7:0]  errcnt;
    logic [31:0] up_lo, up_hi;

    logic [31:0] addr_ext;
    reg_sel_e    sel;
    logic [31:0] rd_mux;
    logic [31:0] status_word;
    logic        writable, bad, wr_en, w1c, snap;

    always_comb begin
        addr_ext    = 32'(address);
        status_word = '0;
        status_word[STATUS_ERR_BIT]      = err;
        status_word[STATUS_CNT_LSB +: 8] = errcnt;

        sel    = SEL_NONE;
        rd_mux = '0;
        if (addr_ext == OFF_ID)      begin sel = SEL_ID;      rd_mux = ID_VALUE;    end
        if (addr_ext == OFF_TS)      begin sel = SEL_TS;      rd_mux = TIMESTAMP;   end
        if (addr_ext == OFF_UPLO)    begin sel = SEL_UPLO;    rd_mux = up_lo;       end
        if (addr_ext == OFF_UPHI)    begin sel = SEL_UPHI;    rd_mux = up_hi;       end
        if (addr_ext == OFF_SCRATCH) begin sel = SEL_SCRATCH; rd_mux = scratch;     end
        if (addr_ext == OFF_CONFIG)  begin sel = SEL_CONFIG;  rd_mux = config_word(ADDR_W, NUM_USER); end
        if (addr_ext == OFF_STATUS)  begin sel = SEL_STATUS;  rd_mux = status_word; end
        for (int unsigned k = 0; k < NUM_USER; k++) begin
            if (addr_ext == OFF_USER + k) begin sel = SEL_USER; rd_mux = user[k]; end
        end

        writable = (sel == SEL_SCRATCH) || (sel == SEL_STATUS) || (sel == SEL_USER);
        bad      = (read && write) || (read && sel == SEL_NONE) || (write && !writable);
        wr_en    = write && !read && writable;
        // The clear request is honoured even alongside a read so that a
        // colliding bad access restarts the count at 1 rather than incrementing.
        w1c      = write && (sel == SEL_STATUS) &&
                   byteenable[STATUS_ERR_BIT / 8] && writedata[STATUS_ERR_BIT];
        snap     = read && (sel == SEL_UPLO);
    end

    sysid_uptime u_uptime (
        .clk     (clk),
        .reset_n (reset_n),
        .snap    (snap),
        .lo      (up_lo),
        .hi      (up_hi)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            scratch       <= '0;
            err           <= 1'b0;
            errcnt        <= '0;
            for (int unsigned k = 0; k < NUM_USER; k++) begin
                user[k] <= USER_INIT[32*k +: 32];
            end
        end else begin
            readdatavalid <= read;
            readdata      <= read ? rd_mux : '0;

            if (wr_en && sel == SEL_SCRATCH) begin
                scratch <= merge_be(scratch, writedata, byteenable);
            end
            for (int unsigned k = 0; k < NUM_USER; k++) begin
                if (wr_en && sel == SEL_USER && addr_ext == OFF_USER + k) begin
                    user[k] <= merge_be(user[k], writedata, byteenable);
                end
            end

            if (bad) begin
                err    <= 1'b1;
                errcnt <= w1c ? 8'd1 : ((errcnt == 8'hFF) ? errcnt : errcnt + 8'd1);
            end else if (w1c) begin
                err    <= 1'b0;
                errcnt <= '0;
            end
        end
    end

    assign irq = err;

endmodule

// File: tb/tb_sysid_ctrl.sv
// tb_sysid_ctrl -- directed self-checking bench for sysid_ctrl.
module tb_sysid_ctrl;

    localparam logic [31:0]  TS    = 32'h6650_1234;
    localparam logic [127:0] UINIT = {32'h0BAD_F00D, 32'h1357_9BDF,
                                      32'hCAFE_F00D, 32'h0123_4567};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] d;

    sysid_ctrl #(
        .TIMESTAMP (TS),
        .USER_INIT (UINIT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] wd, input logic [3:0] be);
        address    = a;
        writedata  = wd;
        byteenable = be;
        write      = 1'b1;
        step();
        write      = 1'b0;
    endtask

    // One read: valid must appear exactly one cycle later, then drop with zero data
    task automatic rd(input logic [4:0] a, output logic [31:0] data);
        address = a;
        read    = 1'b1;
        step();
        read    = 1'b0;
        chk("rdv_pulse", 32'(readdatavalid), 32'd1);
        data = readdata;
        step();
        chk("rdv_idle", 32'(readdatavalid), 32'd0);
        chk("rd_idle_zero", readdata, 32'd0);
    endtask

    initial begin
        // Reset
        reset_n = 1'b0;
        repeat (3) step();
        chk("reset_rdv", 32'(readdatavalid), 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        // Identification reads, first one in the first cycle out of reset
        reset_n = 1'b1;
        rd(5'd0, d); chk("id", d, 32'h2478_C34F);
        rd(5'd1, d); chk("timestamp", d, TS);
        rd(5'd5, d); chk("config", d, 32'h0000_0504);

        // SCRATCH byte lanes
        wr(5'd4, 32'hFFFF_FFFF, 4'b1111);
        wr(5'd4, 32'h1234_5678, 4'b0101);
        rd(5'd4, d); chk("scratch_be", d, 32'hFF34_FF78);
        wr(5'd4, 32'h0000_0000, 4'b0000);
        rd(5'd4, d); chk("scratch_be0", d, 32'hFF34_FF78);
        rd(5'd6, d); chk("status_clean", d, 32'h0000_0000);

        // Uptime low-word read snapshots the high word
        force dut.u_uptime.cnt = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.u_uptime.cnt;
        step();
        rd(5'd2, d); chk("uptime_lo", d, 32'hFFFF_FFFF);
        repeat (3) step();
        rd(5'd3, d); chk("uptime_hi_shadow", d, 32'h0000_0000);
        rd(5'd2, d);
        rd(5'd3, d); chk("uptime_hi_resnap", d, 32'h0000_0001);

        // Error accounting
        wr(5'd0, 32'h1111_1111, 4'b1111);
        rd(5'd7, d); chk("unmapped_read_zero", d, 32'h0000_0000);
        address = 5'd4; writedata = 32'hDEAD_BEEF; byteenable = 4'b1111;
        read = 1'b1; write = 1'b1;
        step();
        read = 1'b0; write = 1'b0;
        chk("rw_rdv", 32'(readdatavalid), 32'd1);
        chk("rw_pre_write_data", readdata, 32'hFF34_FF78);
        step();
        chk("irq_set", 32'(irq), 32'd1);
        rd(5'd6, d); chk("status_three", d, 32'h0000_0301);
        rd(5'd4, d); chk("rw_write_dropped", d, 32'hFF34_FF78);
        wr(5'd6, 32'h0000_0001, 4'b0001);
        chk("irq_cleared", 32'(irq), 32'd0);
        rd(5'd6, d); chk("status_cleared", d, 32'h0000_0000);

        // Saturation, then collision of a bad access with the clear
        address = 5'd7;
        read    = 1'b1;
        repeat (300) step();
        read    = 1'b0;
        step();
        rd(5'd6, d); chk("errcnt_saturated", d, 32'h0000_FF01);
        address = 5'd6; writedata = 32'h0000_0001; byteenable = 4'b0001;
        read = 1'b1; write = 1'b1;
        step();
        read = 1'b0; write = 1'b0;
        chk("w1c_collide_read", readdata, 32'h0000_FF01);
        step();
        rd(5'd6, d); chk("w1c_collide_set_wins", d, 32'h0000_0101);
        chk("w1c_collide_irq", 32'(irq), 32'd1);

        // USER words
        wr(5'd8, 32'hA5A5_A5A5, 4'b1111);
        rd(5'd8, d);  chk("user0_write", d, 32'hA5A5_A5A5);
        wr(5'd9, 32'h1122_3344, 4'b1010);
        rd(5'd9, d);  chk("user1_be", d, 32'h11FE_330D);
        rd(5'd11, d); chk("user3_init", d, 32'h0BAD_F00D);
        rd(5'd12, d); chk("past_user_zero", d, 32'h0000_0000);

        // Reset with a read pending
        reset_n = 1'b0;
        address = 5'd8;
        read    = 1'b1;
        step();
        read    = 1'b0;
        reset_n = 1'b1;
        chk("rst_read_rdv", 32'(readdatavalid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        step();
        chk("rst_read_no_late_rdv", 32'(readdatavalid), 32'd0);
        rd(5'd8, d); chk("user0_reinit", d, 32'h0123_4567);
        rd(5'd4, d); chk("scratch_reset", d, 32'h0000_0000);
        rd(5'd6, d); chk("status_reset", d, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
